aidc_lite_cfg_apb_slv: RTL and testbench
========================================

// Module: aidc_lite_cfg_apb_slv
// PURPOSE
//  APB3 responder holding the compression engine's configuration and status registers.
//  Decodes host APB accesses into SRC/DST/LEN/CMD/STATUS/IEN registers.
//  Issues a one-cycle start pulse to the engine and tracks engine completion.
//  Sits between the APB slave port of the compression top and its AHB-mastering datapath.
// PARAMETERS
//  VERSION   32'h0001_0000  read-only value returned at offset 0x18
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  rst         in   1   synchronous reset, active-high
//  psel_i      in   1   APB select
//  penable_i   in   1   APB enable (access phase)
//  paddr_i     in   32  byte address; only [7:0] decoded, [1:0] ignored
//  pwrite_i    in   1   1=write, 0=read
//  pwdata_i    in   32  write data
//  prdata_o    out  32  read data, valid in access phase
//  pready_o    out  1   tied 1 (zero wait states)
//  pslverr_o   out  1   error response, valid in access phase
//  src_addr_o  out  32  source base address to engine
//  dst_addr_o  out  32  destination base address to engine
//  len_o       out  32  byte length to engine
//  start_o     out  1   one-cycle start pulse to engine
//  done_i      in   1   one-cycle completion pulse from engine
//  irq_o       out  1   level interrupt = STATUS.done & IEN[0]
// BEHAVIOUR
//  Reset: all registers 0, FSM=IDLE.
//   Outputs after reset: prdata_o=0, pslverr_o=0, start_o=0, irq_o=0; pready_o=1 always.
//  Register map:
//   0x00 SRC (RW)
//   0x04 DST (RW)
//   0x08 LEN (RW)
//   0x0C CMD (WO, bit0=start, reads 0)
//   0x10 STATUS (bit0 done W1C, bit1 busy RO)
//   0x14 IEN (RW, bit0)
//   0x18 VERSION (RO)
//  SRC/DST/LEN bits[1:0] are hardwired 0 (word aligned); written low bits are discarded.
//  Setup phase (psel_i & ~penable_i): decode and register prdata_o/pslverr_o.
//   The access phase that follows presents them.
//  Outside an access phase, prdata_o=0 and pslverr_o=0.
//  Write commit: at the posedge ending the access phase (psel_i & penable_i & pwrite_i).
//  Read of an unmapped offset (>0x18): prdata_o=0, pslverr_o=1.
//  Write to an unmapped offset or to VERSION: pslverr_o=1, no state change.
//  FSM IDLE/BUSY/DONE:
//   IDLE or DONE, CMD write with pwdata[0]=1 and LEN!=0:
//    next state BUSY; start_o=1 for exactly the next cycle; STATUS.done cleared.
//   CMD write with LEN==0: pslverr_o=1, no start, state unchanged.
//   CMD write with pwdata[0]=0: no effect, no error.
//   BUSY & done_i: next state DONE, STATUS.done=1.
//   DONE & STATUS write with pwdata[0]=1: done cleared, next state IDLE.
//  While BUSY, writes to SRC/DST/LEN/CMD are ignored and return pslverr_o=1.
//   IEN and STATUS writes remain legal while BUSY.
//  done_i outside BUSY is ignored.
//  STATUS read samples the value at the setup phase.
//   A done_i in that cycle appears on the next read.
//  irq_o is registered: asserts one cycle after STATUS.done&IEN[0] becomes true.
//   It drops one cycle after either one clears.
//  rst asserted mid-BUSY: FSM returns to IDLE, no start_o, registers cleared.
//   A late done_i is then ignored.
// TESTING
//  Reset, then read 0x00..0x18 -> 0,0,0,0,0,0,32'h0001_0000; pslverr_o=0 on all.
//  Write SRC=0x0001_0003, DST=0x0002_0000, LEN=0x1000, CMD=1
//   -> SRC reads 0x0001_0000; start_o high 1 cycle; STATUS reads 0x2.
//  While BUSY, write LEN=0x20 -> pslverr_o=1, LEN still 0x1000.
//   Then drive done_i -> STATUS reads 0x1.
//  IEN=1, completion -> irq_o=1.
//   Write STATUS=1 -> irq_o=0, STATUS=0.
//   Second CMD=1 -> new start_o pulse.
//  LEN=0 then CMD=1 -> pslverr_o=1, no start_o, STATUS=0.
//   Read 0x40 -> prdata_o=0, pslverr_o=1.
//  Assert rst while BUSY, then pulse done_i -> STATUS=0, irq_o=0, start_o never asserted.

Source files
------------

// File: rtl/aidc_lite_cfg_apb_slv.sv
// ---------------------------------------------------------------------------
// aidc_lite_cfg_apb_slv
// APB3 responder holding the compression engine's configuration and status
// registers. Host accesses are decoded into SRC/DST/LEN/CMD/STATUS/IEN,
// a one-cycle start pulse is issued to the engine and its completion pulse
// is tracked by a small IDLE/BUSY/DONE state machine.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   psel_i..pwdata_i APB3 request (only paddr_i[7:2] decoded)
//   prdata_o        read data, driven only in the access phase
//   pready_o        always 1 (zero wait states)
//   pslverr_o       error response, driven only in the access phase
//   src_addr_o      source base address (word aligned)
//   dst_addr_o      destination base address (word aligned)
//   len_o           byte length (word aligned)
//   start_o         one-cycle start pulse to the engine
//   done_i          one-cycle completion pulse from the engine
//   irq_o           registered level interrupt = STATUS.done & IEN[0]
//   dbg_state_o     current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// APB handshake: a transfer is a setup cycle (psel_i & ~penable_i) followed
// by one access cycle (psel_i & penable_i); pready_o is always 1, so every
// access phase completes in one cycle. Read data and the error flag are
// registered in the setup cycle and presented in the access cycle; a write
// commits on the clock edge that ends the access cycle unless it was
// flagged as an error.
// ---------------------------------------------------------------------------
module aidc_lite_cfg_apb_slv #(
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [31:0] src_addr_o,
    output logic [31:0] dst_addr_o,
    output logic [31:0] len_o,
    output logic        start_o,
    input  logic        done_i,
    output logic        irq_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [31:0] r_len;
    logic        r_ien;
    logic [31:0] r_prdata;
    logic        r_pslverr;
    logic        r_start;
    logic        r_irq;

    logic        w_setup;
    logic        w_access;
    logic        w_busy;
    logic        w_done;
    logic [5:0]  w_idx;
    logic [31:0] w_rdata;
    logic        w_rd_err;
    logic        w_wr_err;
    logic        w_commit;
    logic        w_unused;

    assign w_setup  = psel_i & ~penable_i;
    assign w_access = psel_i & penable_i;
    assign w_idx    = paddr_i[7:2];
    assign w_busy   = (r_state == S_BUSY);
    assign w_done   = (r_state == S_DONE);
    assign w_unused = ^{paddr_i[31:8], paddr_i[1:0]};

    // A write flagged at setup never commits, even if the FSM moves between
    // setup and access (e.g. BUSY -> DONE on done_i).
    assign w_commit = w_access & pwrite_i & ~r_pslverr;

    always_comb begin
        w_rdata  = 32'h0;
        w_rd_err = 1'b0;
        case (w_idx)
            6'd0:    w_rdata = r_src;
            6'd1:    w_rdata = r_dst;
            6'd2:    w_rdata = r_len;
            6'd3:    w_rdata = 32'h0;
            6'd4:    w_rdata = {30'h0, w_busy, w_done};
            6'd5:    w_rdata = {31'h0, r_ien};
            6'd6:    w_rdata = VERSION;
            default: w_rd_err = 1'b1;
        endcase
    end

    always_comb begin
        w_wr_err = 1'b0;
        case (w_idx)
            6'd0, 6'd1, 6'd2: w_wr_err = w_busy;
            // Starting with a zero length is refused; CMD bit0=0 is a no-op.
            6'd3:    w_wr_err = w_busy | (pwdata_i[0] & (r_len == 32'h0));
            6'd4, 6'd5: w_wr_err = 1'b0;
            default: w_wr_err = 1'b1;  // VERSION and unmapped offsets
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_src     <= 32'h0;
            r_dst     <= 32'h0;
            r_len     <= 32'h0;
            r_ien     <= 1'b0;
            r_prdata  <= 32'h0;
            r_pslverr <= 1'b0;
            r_start   <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_irq   <= w_done & r_ien;

            if (w_setup) begin
                r_prdata  <= pwrite_i ? 32'h0 : w_rdata;
                r_pslverr <= pwrite_i ? w_wr_err : w_rd_err;
            end

            if (w_busy && done_i) begin
                r_state <= S_DONE;
            end

            if (w_commit) begin
                case (w_idx)
                    6'd0: r_src <= {pwdata_i[31:2], 2'b00};
                    6'd1: r_dst <= {pwdata_i[31:2], 2'b00};
                    6'd2: r_len <= {pwdata_i[31:2], 2'b00};
                    6'd3: begin
                        // Leaving DONE for BUSY clears STATUS.done implicitly.
                        if (pwdata_i[0]) begin
                            r_state <= S_BUSY;
                            r_start <= 1'b1;
                        end
                    end
                    6'd4: begin
                        if (pwdata_i[0] && w_done) begin
                            r_state <= S_IDLE;
                        end
                    end
                    6'd5: r_ien <= pwdata_i[0];
                    default: ;
                endcase
            end
        end
    end

    assign prdata_o    = w_access ? r_prdata : 32'h0;
    assign pslverr_o   = w_access ? r_pslverr : 1'b0;
    assign pready_o    = 1'b1;
    assign src_addr_o  = r_src;
    assign dst_addr_o  = r_dst;
    assign len_o       = r_len;
    assign start_o     = r_start;
    assign irq_o       = r_irq;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_aidc_lite_cfg_apb_slv.sv
// Bench for aidc_lite_cfg_apb_slv. Each APB transfer pushes its expected
// {pslverr, prdata} onto a queue when driven; the access-phase sample pops
// and compares it.
module tb_aidc_lite_cfg_apb_slv;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel_i;
  logic        penable_i;
  logic [31:0] paddr_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;
  logic [31:0] src_addr_o;
  logic [31:0] dst_addr_o;
  logic [31:0] len_o;
  logic        start_o;
  logic        done_i;
  logic        irq_o;
  logic [1:0]  dbg_state_o;

  int unsigned err_cnt = 0;
  int unsigned chk_cnt = 0;
  int unsigned start_cnt = 0;
  int unsigned start_run = 0;
  int unsigned start_run_max = 0;
  logic [32:0] exp_q[$];

  localparam logic [31:0] VER = 32'h0001_0000;

  aidc_lite_cfg_apb_slv dut (
    .clk(clk), .rst(rst),
    .psel_i(psel_i), .penable_i(penable_i), .paddr_i(paddr_i),
    .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o), .len_o(len_o),
    .start_o(start_o), .done_i(done_i), .irq_o(irq_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // start pulse monitor: total pulses and longest high run
  always @(negedge clk) begin
    if (start_o) begin
      start_cnt = start_cnt + ((start_run == 0) ? 1 : 0);
      start_run = start_run + 1;
      if (start_run > start_run_max) start_run_max = start_run;
    end else begin
      start_run = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd,
                          input logic exp_err);
    logic [32:0] exp;
    @(posedge clk); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = addr; pwdata_i = data;
    exp_q.push_back({exp_err, wr ? 32'h0 : exp_rd});
    @(posedge clk); #1;
    penable_i = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, {63'h0, pready_o}, 64'h1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'h0, 64'h1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {31'h0, pslverr_o, prdata_o}, {31'h0, exp});
    end
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
  endtask

  task automatic apb_wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err);
    apb_xfer(tag, 1'b1, addr, data, 32'h0, exp_err);
  endtask

  task automatic apb_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_rd,
                        input logic exp_err);
    apb_xfer(tag, 1'b0, addr, 32'h0, exp_rd, exp_err);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rst_vals [7];
    int unsigned s0;
    rst = 1'b1; psel_i = 1'b0; penable_i = 1'b0; paddr_i = '0;
    pwrite_i = 1'b0; pwdata_i = '0; done_i = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_prdata", {32'h0, prdata_o}, 64'h0);
    check("rst_pslverr", {63'h0, pslverr_o}, 64'h0);
    check("rst_start", {63'h0, start_o}, 64'h0);
    check("rst_irq", {63'h0, irq_o}, 64'h0);

    rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, VER};
    for (int i = 0; i < 7; i++) apb_rd($sformatf("rst_rd_%0d", i), 32'(i * 4), rst_vals[i], 1'b0);

    // configure and start
    apb_wr("wr_src", 32'h00, 32'h0001_0003, 1'b0);
    apb_wr("wr_dst", 32'h04, 32'h0002_0000, 1'b0);
    apb_wr("wr_len", 32'h08, 32'h0000_1000, 1'b0);
    s0 = start_cnt;
    apb_wr("wr_cmd", 32'h0C, 32'h1, 1'b0);
    apb_rd("rd_src_aligned", 32'h00, 32'h0001_0000, 1'b0);
    check("start_one_pulse", 64'(start_cnt - s0), 64'h1);
    check("start_width", 64'(start_run_max), 64'h1);
    check("src_port", {32'h0, src_addr_o}, 64'h0001_0000);
    apb_rd("rd_status_busy", 32'h10, 32'h2, 1'b0);
    apb_rd("rd_cmd_zero", 32'h0C, 32'h0, 1'b0);
    @(negedge clk);
    check("idle_prdata", {32'h0, prdata_o}, 64'h0);

    // writes while busy
    apb_wr("wr_len_busy", 32'h08, 32'h20, 1'b1);
    apb_wr("wr_src_busy", 32'h00, 32'h1234, 1'b1);
    apb_rd("rd_len_kept", 32'h08, 32'h1000, 1'b0);
    pulse_done();
    apb_rd("rd_status_done", 32'h10, 32'h1, 1'b0);
    check("irq_ien0", {63'h0, irq_o}, 64'h0);

    // clear, enable irq, restart
    apb_wr("wr_status_clr", 32'h10, 32'h1, 1'b0);
    apb_rd("rd_status_idle", 32'h10, 32'h0, 1'b0);
    pulse_done();  // ignored outside BUSY
    apb_rd("rd_status_ign", 32'h10, 32'h0, 1'b0);
    apb_wr("wr_ien", 32'h14, 32'h1, 1'b0);
    apb_rd("rd_ien", 32'h14, 32'h1, 1'b0);
    s0 = start_cnt;
    apb_wr("wr_cmd2", 32'h0C, 32'h1, 1'b0);
    repeat (2) @(posedge clk);
    check("start_second", 64'(start_cnt - s0), 64'h1);
    @(posedge clk); #1 done_i = 1'b1;
    @(posedge clk); #1 done_i = 1'b0;
    @(negedge clk);
    check("irq_delay", {63'h0, irq_o}, 64'h0);
    @(negedge clk);
    check("irq_set", {63'h0, irq_o}, 64'h1);
    apb_wr("wr_status_clr2", 32'h10, 32'h1, 1'b0);
    repeat (2) @(negedge clk);
    check("irq_clr", {63'h0, irq_o}, 64'h0);
    apb_rd("rd_status_clr2", 32'h10, 32'h0, 1'b0);
    s0 = start_cnt;
    apb_wr("wr_cmd3", 32'h0C, 32'h1, 1'b0);
    repeat (2) @(posedge clk);
    check("start_third", 64'(start_cnt - s0), 64'h1);
    pulse_done();
    apb_wr("wr_status_clr3", 32'h10, 32'h1, 1'b0);

    // zero length, unmapped, version, CMD bit0=0
    apb_wr("wr_len0", 32'h08, 32'h0, 1'b0);
    s0 = start_cnt;
    apb_wr("wr_cmd_len0", 32'h0C, 32'h1, 1'b1);
    apb_wr("wr_cmd_nop", 32'h0C, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    check("no_start_len0", 64'(start_cnt - s0), 64'h0);
    apb_rd("rd_status_len0", 32'h10, 32'h0, 1'b0);
    apb_rd("rd_unmapped", 32'h40, 32'h0, 1'b1);
    apb_wr("wr_unmapped", 32'h1C, 32'hFFFF_FFFF, 1'b1);
    apb_wr("wr_version", 32'h18, 32'hDEAD_BEEF, 1'b1);
    apb_rd("rd_version", 32'h18, VER, 1'b0);

    // random aligned RW round trips on DST
    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom_range(32'h7FFF_FFFF, 0);
      apb_wr("wr_dst_rand", 32'h04, v, 1'b0);
      apb_rd("rd_dst_rand", 32'h04, {v[31:2], 2'b00}, 1'b0);
    end

    // reset while busy
    apb_wr("wr_len_r", 32'h08, 32'h40, 1'b0);
    apb_wr("wr_cmd_r", 32'h0C, 32'h1, 1'b0);
    apb_rd("rd_status_r", 32'h10, 32'h2, 1'b0);
    do_reset();
    s0 = start_cnt;
    pulse_done();
    repeat (3) @(posedge clk);
    apb_rd("rd_status_after_rst", 32'h10, 32'h0, 1'b0);
    apb_rd("rd_len_after_rst", 32'h08, 32'h0, 1'b0);
    apb_rd("rd_ien_after_rst", 32'h14, 32'h0, 1'b0);
    check("irq_after_rst", {63'h0, irq_o}, 64'h0);
    check("no_start_after_rst", 64'(start_cnt - s0), 64'h0);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
